// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants and the bit-reversal helper
package fft_pkg;
  localparam int NB_DATA  = 12;
  localparam int N_POINTS = 8;
  localparam int LOG2N    = 3;
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) r[5'(i)] = idx[5'(nbits - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: N-entry flop bank, one sync write port, one async read port
//   clk            clock
//   we/waddr/wdata write port
//   raddr/rdata    combinational read port
module fft_reorder_bank #(
  parameter int WIDTH = 24,
  parameter int N     = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [N];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong reorder of bit-reversed FFT output frames into natural bin order
//   i_clk, i_rst_n          clock, async active-low reset
//   s_axis_data_*           input stream, bit-reversed bin order, {imag, real}
//   m_axis_data_*           output stream, natural bin order, tlast on bin N_POINTS-1
//   o_frame_err             one-cycle pulse when input tlast disagrees with the beat counter
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int NB_DATA   = fft_pkg::NB_DATA,
  parameter int N_POINTS  = fft_pkg::N_POINTS,
  parameter int LOG2N     = fft_pkg::LOG2N,
  parameter bit BITREV_EN = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 s_axis_data_tvalid,
  input  logic [2*NB_DATA-1:0] s_axis_data_tdata,
  input  logic                 s_axis_data_tlast,
  output logic                 s_axis_data_tready,
  output logic                 m_axis_data_tvalid,
  output logic [2*NB_DATA-1:0] m_axis_data_tdata,
  output logic                 m_axis_data_tlast,
  input  logic                 m_axis_data_tready,
  output logic                 o_frame_err
);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N_POINTS - 1);
  logic [1:0]           bank_full;
  logic                 wr_bank, rd_bank;
  logic [LOG2N-1:0]     wr_idx, rd_idx, waddr;
  logic                 wr_fire, rd_fire, wr_last, rd_last, wr_done, rd_done;
  logic [2*NB_DATA-1:0] rdata [2];
  assign s_axis_data_tready = !bank_full[wr_bank];
  assign m_axis_data_tvalid = bank_full[rd_bank];
  assign m_axis_data_tdata  = rd_bank ? rdata[1] : rdata[0];
  assign m_axis_data_tlast  = m_axis_data_tvalid & rd_last;
  assign wr_fire = s_axis_data_tvalid & s_axis_data_tready;
  assign rd_fire = m_axis_data_tvalid & m_axis_data_tready;
  assign wr_last = wr_idx == LAST;
  assign rd_last = rd_idx == LAST;
  assign wr_done = wr_fire & wr_last;
  assign rd_done = rd_fire & rd_last;
  assign waddr   = BITREV_EN ? LOG2N'(bitrev(32'(wr_idx), LOG2N)) : wr_idx;
  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_reorder_bank #(.WIDTH(2*NB_DATA), .N(N_POINTS), .AW(LOG2N)) u_bank (
      .clk   (i_clk),
      .we    (wr_fire & (wr_bank == 1'(g))),
      .waddr (waddr),
      .wdata (s_axis_data_tdata),
      .raddr (rd_idx),
      .rdata (rdata[g])
    );
  end
  // write and read always target different banks, so set and clear never collide
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      bank_full   <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= wr_fire & (s_axis_data_tlast != wr_last);
      bank_full   <= (bank_full | {wr_done & wr_bank, wr_done & ~wr_bank})
                     & ~{rd_done & rd_bank, rd_done & ~rd_bank};
      if (wr_fire) wr_idx <= wr_last ? '0 : wr_idx + LOG2N'(1);
      if (rd_fire) rd_idx <= rd_last ? '0 : rd_idx + LOG2N'(1);
      if (wr_done) wr_bank <= ~wr_bank;
      if (rd_done) rd_bank <= ~rd_bank;
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: randomized/directed check of the reorder buffer against a frame-level queue model
module tb_fft_out_reorder;
  localparam int NB = 12;
  localparam int W  = 2 * NB;
  localparam int N  = 8;
  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         m_tready = 1'b0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tready, m_tvalid, m_tlast, frame_err;
  logic [W-1:0] m_tdata;
  logic         b_tready, b_tvalid, b_tlast, b_err;
  logic [W-1:0] b_tdata;
  beat_t        in_q[$];
  logic [W-1:0] out_q[$];
  logic [W-1:0] byp_q[$];
  logic [W-1:0] part[N];
  int           wcnt = 0;
  logic         exp_err = 1'b0;
  int           n_chk = 0;
  int           n_err = 0;
  always #5 i_clk = ~i_clk;
  fft_out_reorder #(.BITREV_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .s_axis_data_tvalid(s_tvalid), .s_axis_data_tdata(s_tdata), .s_axis_data_tlast(s_tlast),
    .s_axis_data_tready(s_tready),
    .m_axis_data_tvalid(m_tvalid), .m_axis_data_tdata(m_tdata), .m_axis_data_tlast(m_tlast),
    .m_axis_data_tready(m_tready), .o_frame_err(frame_err)
  );
  fft_out_reorder #(.BITREV_EN(1'b0)) byp (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .s_axis_data_tvalid(s_tvalid), .s_axis_data_tdata(s_tdata), .s_axis_data_tlast(s_tlast),
    .s_axis_data_tready(b_tready),
    .m_axis_data_tvalid(b_tvalid), .m_axis_data_tdata(b_tdata), .m_axis_data_tlast(b_tlast),
    .m_axis_data_tready(m_tready), .o_frame_err(b_err)
  );
  function automatic int rev3(input int j);
    int r;
    r = 0;
    for (int b = 0; b < 3; b++) if ((j >> b) & 1) r = r | (1 << (2 - b));
    return r;
  endfunction
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_outputs();
    int   sz;
    logic ev, er, el;
    sz = out_q.size();
    ev = sz > 0;
    er = (sz + N - 1) / N < 2;
    el = sz % N == 1;
    chk("s_tready", W'(s_tready), W'(er));
    chk("m_tvalid", W'(m_tvalid), W'(ev));
    chk("m_tlast", W'(m_tlast), W'(el));
    chk("frame_err", W'(frame_err), W'(exp_err));
    chk("byp_tready", W'(b_tready), W'(er));
    chk("byp_tvalid", W'(b_tvalid), W'(ev));
    chk("byp_tlast", W'(b_tlast), W'(el));
    chk("byp_frame_err", W'(b_err), W'(exp_err));
    if (ev) begin
      chk("m_tdata", m_tdata, out_q[0]);
      chk("byp_tdata", b_tdata, byp_q[0]);
    end
  endtask
  // model: up to two complete frames buffered; a frame is readable the cycle after its last accept
  task automatic cycle(input logic r, input bit gap);
    logic v, wf, rf;
    v = in_q.size() > 0 && !gap;
    s_tvalid = v;
    s_tdata  = v ? in_q[0].d : '0;
    s_tlast  = v ? in_q[0].l : 1'b0;
    m_tready = r;
    wf = v && (out_q.size() + N - 1) / N < 2;
    rf = r && out_q.size() > 0;
    @(posedge i_clk);
    exp_err = wf && (s_tlast != (wcnt == N - 1));
    if (rf) begin
      void'(out_q.pop_front());
      void'(byp_q.pop_front());
    end
    if (wf) begin
      part[wcnt] = in_q[0].d;
      void'(in_q.pop_front());
      wcnt++;
      if (wcnt == N) begin
        for (int j = 0; j < N; j++) begin
          out_q.push_back(part[rev3(j)]);
          byp_q.push_back(part[j]);
        end
        wcnt = 0;
      end
    end
    @(negedge i_clk);
    check_outputs();
  endtask
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++)
      cycle(mode == 1 || (mode == 2 && i % 2 == 0) || (mode == 3 && $urandom_range(0, 1) == 1),
            mode == 3 && $urandom_range(0, 3) == 0);
  endtask
  task automatic push_frame(input bit ramp, input logic [7:0] tl);
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.d = ramp ? {12'(-k), 12'(k)} : W'($urandom);
      b.l = tl[k];
      in_q.push_back(b);
    end
  endtask
  initial begin
    repeat (3) @(negedge i_clk);
    check_outputs();
    i_rst_n = 1'b1;
    push_frame(1'b1, 8'h80);
    run(20, 1);
    repeat (4) push_frame(1'b0, 8'h80);
    run(40, 1);
    repeat (3) push_frame(1'b0, 8'h80);
    run(20, 0);
    run(40, 2);
    run(20, 1);
    push_frame(1'b1, 8'h90);
    push_frame(1'b0, 8'h00);
    run(24, 1);
    push_frame(1'b0, 8'h80);
    run(9, 0);
    push_frame(1'b0, 8'h80);
    run(5, 1);
    #3 i_rst_n = 1'b0;
    #1;
    in_q.delete();
    out_q.delete();
    byp_q.delete();
    wcnt = 0;
    exp_err = 1'b0;
    check_outputs();
    s_tvalid = 1'b0;
    @(negedge i_clk);
    check_outputs();
    i_rst_n = 1'b1;
    push_frame(1'b1, 8'h80);
    run(20, 1);
    repeat (6) push_frame(1'b0, 8'h80);
    run(150, 3);
    run(40, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
